// File: rtl/latch_wr_arb_pkg.sv
// latch_wr_arb_pkg: shared types and defaults for the latch write arbiter.
// Contents: FSM state encoding, default parameter values, and the width
// function for the SETUP/PULSE/HOLD phase down-counter.
package latch_wr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } arb_state_e;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_WIDTH     = 16;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_PULSE_CYC = 1;
    localparam int DEF_HOLD_CYC  = 1;

    // The counter is reloaded on every phase entry, so it only has to hold
    // the longest phase length minus one. The extra bit is kept as margin.
    function automatic int phase_cnt_width(input int setup_cyc, input int pulse_cyc,
                                           input int hold_cyc);
        int longest;
        longest = setup_cyc;
        if (pulse_cyc > longest) longest = pulse_cyc;
        if (hold_cyc > longest) longest = hold_cyc;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/latch_wr_arbiter_if.sv
// latch_wr_arbiter_if: requester handshake plus latch-bank drive signals.
// Modports: master (requester side), slave (arbiter), bank (latch bank).
interface latch_wr_arbiter_if
    import latch_wr_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      latch_d;
    logic                  latch_wen;
    logic                  busy;

    modport master (
        output req,
        output wdata,
        input  done,
        input  busy
    );

    modport slave (
        input  req,
        input  wdata,
        output done,
        output latch_d,
        output latch_wen,
        output busy
    );

    modport bank (
        input latch_d,
        input latch_wen
    );

endinterface

// File: rtl/latch_wr_arbiter_rr_arbiter.sv
// rr_arbiter: picks one requester, searching upward from ptr and wrapping.
// Build option LATCH_WR_ARB_FIXED_PRIO_EN: the search always starts at
// requester 0 (plain priority encoder, ptr ignored).
module rr_arbiter
    import latch_wr_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] winner
);

    int               start;
    logic [IDX_W-1:0] cand;
    logic             found;

    // first requester at or after the start index wins
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
`ifdef LATCH_WR_ARB_FIXED_PRIO_EN
        start  = 0;
`else
        start  = int'(ptr);
`endif
        for (int i = 0; i < NREQ; i++) begin
            cand = IDX_W'((start + i) % NREQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        if (found) grant[winner] = 1'b1;
    end

endmodule

// File: rtl/latch_wr_arbiter.sv
// latch_wr_arbiter: shares one gated-latch bank among NREQ requesters and
// runs each write as SETUP -> PULSE -> HOLD on the registered latch enable.
// Build option LATCH_WR_ARB_FIXED_PRIO_EN: fixed priority (lowest index
// wins, no round-robin pointer). Default build is round-robin.
//
// state | meaning
// IDLE  | no write in flight; arbitrate, capture winner data into latch_d
// SETUP | latch_d stable, latch_wen low
// PULSE | latch_wen high, latches transparent
// HOLD  | latch_wen low, latch_d held; done pulses in the last HOLD cycle
module latch_wr_arbiter
    import latch_wr_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input logic               clk,
    input logic               rst_n,
    latch_wr_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = phase_cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    arb_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [NREQ-1:0]  win_oh;
    logic [WIDTH-1:0] latch_d_q;
    logic             latch_wen_q;
    logic             busy_q;
    logic [NREQ-1:0]  done_q;
    logic [NREQ-1:0]  arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic             start_wr;

    assign start_wr = (state == ST_IDLE) && (|bus.req);

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (bus.req),
        .ptr    (rr_ptr),
        .grant  (arb_grant),
        .winner (arb_idx)
    );

`ifdef LATCH_WR_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    // after each grant, priority moves to the requester after the winner
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (start_wr) begin
            rr_ptr <= (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
        end
    end
`endif

    // write sequencer: phase down-counter with terminal count at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            win_oh      <= '0;
            latch_d_q   <= '0;
            latch_wen_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= '0;
        end else begin
            done_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (start_wr) begin
                        state     <= ST_SETUP;
                        cnt       <= SETUP_LOAD;
                        win_oh    <= arb_grant;
                        latch_d_q <= bus.wdata[int'(arb_idx)*WIDTH +: WIDTH];
                        busy_q    <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        state       <= ST_PULSE;
                        cnt         <= PULSE_LOAD;
                        latch_wen_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        state       <= ST_HOLD;
                        cnt         <= HOLD_LOAD;
                        latch_wen_q <= 1'b0;
                        // a one-cycle HOLD is also the last HOLD cycle
                        if (HOLD_CYC == 1) done_q <= win_oh;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_ONE) done_q <= win_oh;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    latch_wen_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.latch_d   = latch_d_q;
    assign bus.latch_wen = latch_wen_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_latch_wr_arbiter.sv
// tb_latch_wr_arbiter: two arbiters (1/1/1 and 2/3/2 phase timing) driven by
// directed scenarios and random requesters, compared every cycle against a
// write-timeline reference model.
module tb_latch_wr_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int S_C [2] = '{1, 2};
    localparam int P_C [2] = '{1, 3};
    localparam int H_C [2] = '{1, 2};

    logic clk;
    logic rst_n;

    latch_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(W)) bus0 ();
    latch_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(W)) bus1 ();

    latch_wr_arbiter #(
        .NREQ(NREQ), .WIDTH(W), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    latch_wr_arbiter #(
        .NREQ(NREQ), .WIDTH(W), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    logic [NREQ-1:0]   req_v   [2];
    logic [NREQ*W-1:0] wdata_v [2];
    logic [NREQ-1:0]   done_o  [2];
    logic [W-1:0]      d_o     [2];
    logic              wen_o   [2];
    logic              busy_o  [2];

    assign bus0.req   = req_v[0];
    assign bus0.wdata = wdata_v[0];
    assign bus1.req   = req_v[1];
    assign bus1.wdata = wdata_v[1];
    assign done_o[0]  = bus0.done;
    assign done_o[1]  = bus1.done;
    assign d_o[0]     = bus0.latch_d;
    assign d_o[1]     = bus1.latch_d;
    assign wen_o[0]   = bus0.latch_wen;
    assign wen_o[1]   = bus1.latch_wen;
    assign busy_o[0]  = bus0.busy;
    assign busy_o[1]  = bus1.busy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks;
    int n_fail;
    int cyc;

    // reference model: one in-flight write described by its grant cycle
    bit         m_act  [2];
    int         m_t    [2];
    int         m_free [2];
    int         m_win  [2];
    logic [W-1:0] m_data [2];
    int         m_ptr  [2];
    logic [W-1:0] bank [2];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int tot(input int d);
        return S_C[d] + P_C[d] + H_C[d];
    endfunction

    function automatic logic e_wen(input int d, input int c);
        return m_act[d] && (c >= m_t[d] + 1 + S_C[d]) && (c <= m_t[d] + S_C[d] + P_C[d]);
    endfunction

    function automatic logic e_busy(input int d, input int c);
        return m_act[d] && (c >= m_t[d] + 1) && (c <= m_t[d] + tot(d));
    endfunction

    function automatic logic [NREQ-1:0] e_done(input int d, input int c);
        logic [NREQ-1:0] v;
        v = '0;
        if (m_act[d] && c == m_t[d] + tot(d)) v[m_win[d]] = 1'b1;
        return v;
    endfunction

    function automatic int pick(input int d, input logic [NREQ-1:0] r);
`ifdef LATCH_WR_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++)
            if (r[k]) return k;
`else
        for (int k = 0; k < NREQ; k++)
            if (r[(m_ptr[d] + k) % NREQ]) return (m_ptr[d] + k) % NREQ;
`endif
        return 0;
    endfunction

    // apply the inputs that the coming rising edge will sample
    task automatic model_edge();
        int w;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_act[d]  = 1'b0;
                m_data[d] = '0;
                m_ptr[d]  = 0;
                m_free[d] = cyc + 1;
            end else if (cyc >= m_free[d] && req_v[d] != '0) begin
                w         = pick(d, req_v[d]);
                m_act[d]  = 1'b1;
                m_t[d]    = cyc;
                m_win[d]  = w;
                m_data[d] = wdata_v[d][w*W +: W];
                m_free[d] = cyc + tot(d) + 1;
                m_ptr[d]  = (w + 1) % NREQ;
            end
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            if (wen_o[d] === 1'b1) bank[d] = d_o[d];
            check_val($sformatf("dut%0d_wen", d), 32'(wen_o[d]), 32'(e_wen(d, cyc)));
            check_val($sformatf("dut%0d_busy", d), 32'(busy_o[d]), 32'(e_busy(d, cyc)));
            check_val($sformatf("dut%0d_done", d), 32'(done_o[d]), 32'(e_done(d, cyc)));
            check_val($sformatf("dut%0d_latch_d", d), 32'(d_o[d]), 32'(m_data[d]));
            if (e_done(d, cyc) != '0)
                check_val($sformatf("dut%0d_bank", d), 32'(bank[d]), 32'(m_data[d]));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_done(input int d, input int i, input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget && at < 0; n++) begin
            step();
            if (done_o[d][i]) begin
                at = cyc;
                req_v[d][i] = 1'b0;
            end
        end
        check_val($sformatf("dut%0d_done_seen_%0d", d, i), 32'(at >= 0), 32'd1);
    endtask

    // random requesters honouring the protocol
    task automatic agent_step();
        logic [NREQ-1:0] dn;
        for (int d = 0; d < 2; d++) begin
            dn = e_done(d, cyc);
            for (int i = 0; i < NREQ; i++) begin
                if (dn[i]) begin
                    req_v[d][i] = 1'b0;
                end else if (m_act[d] && m_win[d] == i && cyc > m_t[d] && cyc < m_t[d] + tot(d)) begin
                    if ($urandom_range(7) == 0) wdata_v[d][i*W +: W] = W'($urandom);
                    if ($urandom_range(15) == 0) req_v[d][i] = 1'b0;
                end else if (!req_v[d][i] && $urandom_range(3) == 0) begin
                    wdata_v[d][i*W +: W] = W'($urandom);
                    req_v[d][i] = 1'b1;
                end
            end
        end
    endtask

    int order [4];
    int at_c  [4];
    int n_done, cnt0, cnt1, exp0, exp1, blen, dchg, at, t0;
    logic [15:0] pat;
    logic [NREQ-1:0] any_done;
    bit seen_done;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 1'b0; m_t[d] = 0; m_free[d] = 0; m_win[d] = 0;
            m_data[d] = '0; m_ptr[d] = 0; bank[d] = '0;
            req_v[d] = '0; wdata_v[d] = '0;
        end
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // idle after reset
        for (int n = 0; n < 10; n++) begin
            step();
            check_val("idle_outputs", 32'({wen_o[0], busy_o[0], done_o[0], d_o[0]}), 32'd0);
        end

        // requester 2 writes A5A5 on the default-timing arbiter
        wdata_v[0][2*W +: W] = 16'hA5A5;
        req_v[0][2] = 1'b1;
        step();
        check_val("a5_latch_d_t1", 32'(d_o[0]), 32'h0000A5A5);
        check_val("a5_wen_t1", 32'(wen_o[0]), 32'd0);
        step();
        check_val("a5_wen_t2", 32'(wen_o[0]), 32'd1);
        step();
        check_val("a5_done_t3", 32'(done_o[0]), 32'b0100);
        check_val("a5_wen_t3", 32'(wen_o[0]), 32'd0);
        req_v[0][2] = 1'b0;
        step();
        check_val("a5_bank", 32'(bank[0]), 32'h0000A5A5);
        check_val("a5_busy_t4", 32'(busy_o[0]), 32'd0);

        // four simultaneous requests after reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            wdata_v[0][i*W +: W] = 16'(32'h1000 + i);
            order[i] = -1;
            at_c[i]  = 0;
        end
        req_v[0] = '1;
        n_done = 0;
        for (int n = 0; n < 30 && n_done < 4; n++) begin
            step();
            if (done_o[0] != '0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (done_o[0][i]) begin
                        order[n_done] = i;
                        at_c[n_done]  = cyc;
                        req_v[0][i]   = 1'b0;
                    end
                end
                n_done++;
            end
        end
        check_val("order_count", 32'(n_done), 32'd4);
        for (int k = 0; k < 4; k++) check_val($sformatf("order_%0d", k), 32'(order[k]), 32'(k));
        for (int k = 1; k < 4; k++) check_val($sformatf("order_gap_%0d", k), 32'(at_c[k] - at_c[k-1]), 32'd4);

        // all requesters held high continuously
        req_v[0] = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req_v[0] = '1;
        cnt0 = 0;
        cnt1 = 0;
        for (int n = 0; n < 32; n++) begin
            step();
            if (done_o[0][0]) cnt0++;
            if (done_o[0][1]) cnt1++;
        end
`ifdef LATCH_WR_ARB_FIXED_PRIO_EN
        exp0 = 8;
        exp1 = 0;
`else
        exp0 = 2;
        exp1 = 2;
`endif
        check_val("contend_cnt0", 32'(cnt0), 32'(exp0));
        check_val("contend_cnt1", 32'(cnt1), 32'(exp1));
        req_v[0] = '0;
        for (int n = 0; n < 4; n++) step();

        // 2/3/2 timing, winner data changed while latches are open
        wdata_v[1][0 +: W] = 16'h3C3C;
        req_v[1][0] = 1'b1;
        pat = '0;
        blen = 0;
        dchg = 0;
        seen_done = 1'b0;
        for (int n = 0; n < 20 && !seen_done; n++) begin
            step();
            if (busy_o[1]) begin
                pat = {pat[14:0], wen_o[1]};
                blen++;
                if (d_o[1] !== 16'h3C3C) dchg++;
            end
            if (wen_o[1]) wdata_v[1][0 +: W] = 16'hFFFF;
            if (done_o[1][0]) begin
                req_v[1][0] = 1'b0;
                seen_done = 1'b1;
            end
        end
        check_val("p232_pattern", 32'(pat), 32'b0011100);
        check_val("p232_len", 32'(blen), 32'd7);
        check_val("p232_d_const", 32'(dchg), 32'd0);
        check_val("p232_done", 32'(seen_done), 32'd1);
        step();

        // winner drops req during SETUP
        wdata_v[1][3*W +: W] = 16'h0F0F;
        req_v[1][3] = 1'b1;
        step();
        t0 = cyc - 1;
        req_v[1][3] = 1'b0;
        wait_done(1, 3, 15, at);
        check_val("drop_latency", 32'(at - t0), 32'd7);
        step();
        check_val("drop_bank", 32'(bank[1]), 32'h00000F0F);

        // reset in the middle of PULSE
        wdata_v[0][1*W +: W] = 16'h1234;
        req_v[0][1] = 1'b1;
        step();
        step();
        check_val("rst_pulse_wen_before", 32'(wen_o[0]), 32'd1);
        rst_n = 1'b0;
        req_v[0][1] = 1'b0;
        step();
        check_val("rst_pulse_wen", 32'(wen_o[0]), 32'd0);
        check_val("rst_pulse_busy", 32'(busy_o[0]), 32'd0);
        check_val("rst_pulse_d", 32'(d_o[0]), 32'd0);
        rst_n = 1'b1;
        any_done = '0;
        for (int n = 0; n < 6; n++) begin
            step();
            any_done |= done_o[0];
        end
        check_val("rst_no_done", 32'(any_done), 32'd0);
        wdata_v[0][1*W +: W] = 16'h5678;
        req_v[0][1] = 1'b1;
        t0 = cyc;
        wait_done(0, 1, 10, at);
        check_val("post_rst_latency", 32'(at - t0), 32'd3);
        check_val("post_rst_d", 32'(d_o[0]), 32'h00005678);

        // random traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(199) != 0);
            agent_step();
            step();
        end
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/latch_wr_arbiter.md
# latch_wr_arbiter

Shares one bank of gated D latches (`d_latch` cells, transparent while `wen`=1) among `NREQ` requesters. It also sequences each write so that latch data is stable before the enable rises and stays stable after it falls. Each granted write runs as a fixed SETUP → PULSE → HOLD enable sequence, and the requester is told when it completes. The block sits between the register-file/control logic and the structural latch bank.

## Interface
- `NREQ`, 4 — number of requesters, ≥2
- `WIDTH`, 16 — latch bank data width
- `SETUP_CYC`, 1 — cycles `latch_d` is stable with `latch_wen`=0 before the pulse, ≥1
- `PULSE_CYC`, 1 — cycles `latch_wen`=1, ≥1
- `HOLD_CYC`, 1 — cycles `latch_d` is held with `latch_wen`=0 after the pulse, ≥1

- `clk` in 1 — single clock; all state updates on the rising edge
- `rst_n` in 1 — reset, synchronous, active-low
- `req` in NREQ — write request per requester; level, held until `done`
- `wdata` in NREQ*WIDTH — requester i data in bits [i*WIDTH +: WIDTH]
- `done` out NREQ — one-hot, one-cycle completion pulse to the winner
- `latch_d` out WIDTH — registered data to the latch bank
- `latch_wen` out 1 — registered, glitch-free latch enable
- `busy` out 1 — high in any state other than IDLE

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD.
- IDLE: if any `req` bit is high, arbitrate, capture the winner's `wdata` into `latch_d`, load the phase counter with `SETUP_CYC-1`, and go to SETUP. If no bit is high, stay in IDLE.
- SETUP: `latch_wen`=0. When the counter reaches 0, load `PULSE_CYC-1` and go to PULSE.
- PULSE: `latch_wen`=1. When the counter reaches 0, load `HOLD_CYC-1` and go to HOLD.
- HOLD: `latch_wen`=0. When the counter reaches 0, pulse `done[winner]` and return to IDLE.
- `latch_d` changes only on the IDLE→SETUP transition. It holds its value through IDLE after a write.
- Default arbitration is round-robin. Priority starts at the requester after the last winner. After reset, requester 0 has highest priority.
- Requester protocol: keep `req` and `wdata` stable until `done` is seen, then deassert `req` at the next edge. The arbiter samples `wdata` only once, on the grant edge.
- If the winner drops `req` mid-operation, the write still completes and `done` still pulses.
- New requests arriving during a write wait; they are considered at the next IDLE.
- The phase counter is `$clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC))+1` bits wide, unsigned. No wrap occurs because the counter is reloaded at every phase entry.

## Timing
- Reset values: `latch_wen`=0, `latch_d`=0, `done`=0, `busy`=0, state=IDLE, RR pointer=0.
- A request seen in IDLE at edge T enters SETUP at T+1. `latch_wen` rises at T+1+SETUP_CYC and falls at T+1+SETUP_CYC+PULSE_CYC.
- `done` is high during the final HOLD cycle.
- Grant-to-done latency is SETUP_CYC+PULSE_CYC+HOLD_CYC cycles. With defaults, back-to-back writes take 4 cycles each, because one IDLE cycle separates writes.
- `rst_n` low at any edge, including mid-PULSE, forces all reset values at that edge. The interrupted latch contents are undefined and no `done` is issued.
- Simultaneous requests in IDLE produce exactly one grant. Losers are served in RR order on later IDLE cycles.

## Configuration
- `LATCH_WR_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, lowest index wins; the RR pointer is removed.
  - Undefined: round-robin as described above.

## Structure
- `latch_wr_arb_pkg` holds:
  - the state enum (IDLE/SETUP/PULSE/HOLD)
  - default parameter constants
  - the phase counter width function
- Sub-module `rr_arbiter`:
  - inputs: `req`, pointer
  - outputs: one-hot grant and winner index
  - in fixed-priority mode it degenerates to a priority encoder

## Test plan
- Reset, then idle → `latch_wen`=0, `latch_d`=0, `busy`=0, `done`=0 for 10 cycles.
- Requester 2 writes 16'hA5A5 with defaults → `latch_d`=A5A5 from T+1; `latch_wen`=1 only in cycle T+2; `done`=4'b0100 at T+3; a `d_latch` bank model reads A5A5.
- All 4 requesters assert simultaneously with distinct data → done order 0,1,2,3, each 4 cycles apart. With `LATCH_WR_ARB_FIXED_PRIO_EN`, requester 0 re-requesting continuously starves the others.
- SETUP=2, PULSE=3, HOLD=2 → exactly 2 low, 3 high, 2 low cycles of `latch_wen`, with `latch_d` constant throughout.
- `wdata` of the winner changed mid-PULSE → `latch_d` unchanged. Winner drops `req` mid-SETUP → write still completes with `done`.
- `rst_n` low during PULSE → `latch_wen`=0 and state IDLE at that edge, no `done`; the next request is served normally.
